// File: rtl/tdm_demux_4bit_pkg.sv
// Shared definitions for the 4-bit TDM demultiplexer.
//   state_e : frame-alignment state encodings
//   SEL_A / SEL_B : channel codes reported on Sel
package tdm_demux_4bit_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    EXP_A = 2'b01,
    EXP_B = 2'b10
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register.
//   Clk, Rst_n : clock, async active-low reset
//   load_i     : capture data_i this edge (sets valid)
//   data_i     : word to capture
//   ready_i    : downstream accepts data_o
//   data_o     : buffered word (stable while valid_o=1 and ready_i=0)
//   valid_o    : buffered word not yet delivered
module demux_slot #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // A load wins over a drain, so a simultaneous load and drain keeps valid
  // high and replaces the data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/tdm_demux_4bit.sv
// Receive-side 2:1 TDM demultiplexer. Frame-flagged words go to channel A,
// the following unflagged word to channel B. A three-state machine tracks
// alignment, drops misaligned words and counts framing errors.
//
//   state | meaning
//   HUNT  | unaligned, waiting for a Frame word
//   EXP_B | last routed word was A, expecting the B word
//   EXP_A | last routed word was B, expecting the next Frame word
//
// Ports: Clk/Rst_n clock and async active-low reset; Din/Din_valid/Frame
// input stream with Din_ready back-pressure; A_out/A_valid/A_ready and
// B_out/B_valid/B_ready per-channel outputs; Locked (not HUNT), Sel (channel
// of last routed word), Err_cnt (saturating framing-error count).
module tdm_demux_4bit
  import tdm_demux_4bit_pkg::*;
#(
  parameter int W     = 4,
  parameter int ERR_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [W-1:0]     Din,
  input  logic             Din_valid,
  input  logic             Frame,
  output logic             Din_ready,
  output logic [W-1:0]     A_out,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [W-1:0]     B_out,
  output logic             B_valid,
  input  logic             B_ready,
  output logic             Locked,
  output logic             Sel,
  output logic [ERR_W-1:0] Err_cnt
);

  state_e           state_q, state_d;
  logic             locked_q;
  logic             sel_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic accept;
  logic load_a, load_b, frm_err;

  // Both slots must be able to take a word, so the decision never depends on
  // which channel the incoming word belongs to.
  assign Din_ready = (!A_valid || A_ready) && (!B_valid || B_ready);
  assign accept    = Din_valid && Din_ready;

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    frm_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (Frame) begin
            load_a  = 1'b1;
            state_d = EXP_B;
          end
        end
        EXP_B: begin
          if (Frame) begin
            // Early frame marker: resync on it instead of losing the word.
            load_a  = 1'b1;
            frm_err = 1'b1;
          end else begin
            load_b  = 1'b1;
            state_d = EXP_A;
          end
        end
        EXP_A: begin
          if (Frame) begin
            load_a  = 1'b1;
            state_d = EXP_B;
          end else begin
            frm_err = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= HUNT;
      locked_q  <= 1'b0;
      sel_q     <= SEL_A;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d != HUNT);
      if (load_a) begin
        sel_q <= SEL_A;
      end else if (load_b) begin
        sel_q <= SEL_B;
      end
      if (frm_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  assign Locked  = locked_q;
  assign Sel     = sel_q;
  assign Err_cnt = err_cnt_q;

  demux_slot #(.W(W)) u_slot_a (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load_i  (load_a),
    .data_i  (Din),
    .ready_i (A_ready),
    .data_o  (A_out),
    .valid_o (A_valid)
  );

  demux_slot #(.W(W)) u_slot_b (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load_i  (load_b),
    .data_i  (Din),
    .ready_i (B_ready),
    .data_o  (B_out),
    .valid_o (B_valid)
  );

endmodule

// File: tb/tb_tdm_demux_4bit.sv
module tb_tdm_demux_4bit;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] Din;
  logic       Din_valid;
  logic       Frame;
  logic       Din_ready;
  logic [3:0] A_out;
  logic       A_valid;
  logic       A_ready;
  logic [3:0] B_out;
  logic       B_valid;
  logic       B_ready;
  logic       Locked;
  logic       Sel;
  logic [7:0] Err_cnt;

  int checks = 0;
  int errors = 0;

  tdm_demux_4bit #(.W(4), .ERR_W(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Frame     (Frame),
    .Din_ready (Din_ready),
    .A_out     (A_out),
    .A_valid   (A_valid),
    .A_ready   (A_ready),
    .B_out     (B_out),
    .B_valid   (B_valid),
    .B_ready   (B_ready),
    .Locked    (Locked),
    .Sel       (Sel),
    .Err_cnt   (Err_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: alignment tracked as "what the next word should be".
  // 0 = no alignment yet, 1 = a B word is due, 2 = an A (Frame) word is due.
  int         m_want;
  logic [3:0] m_ad, m_bd;
  logic       m_av, m_bv, m_sel;
  int         m_err;

  function automatic void model_reset();
    m_want = 0; m_ad = '0; m_bd = '0; m_av = 0; m_bv = 0; m_sel = 0; m_err = 0;
  endfunction

  function automatic logic model_ready(input logic ar, input logic br);
    return (!m_av || ar) && (!m_bv || br);
  endfunction

  function automatic void model_edge(input logic [3:0] d, input logic dv,
                                     input logic fr, input logic ar, input logic br);
    logic acc, to_a, to_b, bad;
    acc  = dv && model_ready(ar, br);
    to_a = 0; to_b = 0; bad = 0;
    if (m_av && ar) m_av = 0;
    if (m_bv && br) m_bv = 0;
    if (acc) begin
      if (fr) begin
        to_a = 1;
        if (m_want == 1) bad = 1;
        m_want = 1;
      end else if (m_want == 1) begin
        to_b = 1;
        m_want = 2;
      end else if (m_want == 2) begin
        bad = 1;
        m_want = 0;
      end
    end
    if (bad && m_err < 255) m_err++;
    if (to_a) begin m_ad = d; m_av = 1; m_sel = 0; end
    if (to_b) begin m_bd = d; m_bv = 1; m_sel = 1; end
  endfunction

  task automatic step(input logic [3:0] d, input logic dv, input logic fr,
                      input logic ar, input logic br, input string tag);
    logic exp_rdy;
    Din = d; Din_valid = dv; Frame = fr; A_ready = ar; B_ready = br;
    #1;
    exp_rdy = model_ready(ar, br);
    checks++;
    if (Din_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s din_ready got %b want %b at %0t", tag, Din_ready, exp_rdy, $time);
    end
    @(posedge Clk);
    model_edge(d, dv, fr, ar, br);
    #1;
    checks++;
    if (A_valid !== m_av || (m_av && A_out !== m_ad)) begin
      errors++;
      $display("FAIL %s chan_a got v=%b d=%h want v=%b d=%h at %0t", tag, A_valid, A_out, m_av, m_ad, $time);
    end
    checks++;
    if (B_valid !== m_bv || (m_bv && B_out !== m_bd)) begin
      errors++;
      $display("FAIL %s chan_b got v=%b d=%h want v=%b d=%h at %0t", tag, B_valid, B_out, m_bv, m_bd, $time);
    end
    checks++;
    if (Locked !== (m_want != 0) || Sel !== m_sel || Err_cnt !== 8'(m_err)) begin
      errors++;
      $display("FAIL %s status got lock=%b sel=%b err=%0d want lock=%b sel=%b err=%0d at %0t",
               tag, Locked, Sel, Err_cnt, (m_want != 0), m_sel, m_err, $time);
    end
  endtask

  task automatic do_reset();
    Rst_n = 0; Din = '0; Din_valid = 0; Frame = 0; A_ready = 0; B_ready = 0;
    model_reset();
    @(negedge Clk);
    Rst_n = 1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (A_valid !== 0 || B_valid !== 0 || A_out !== 4'h0 || B_out !== 4'h0 ||
        Locked !== 0 || Sel !== 0 || Err_cnt !== 8'h00 || Din_ready !== 1) begin
      errors++;
      $display("FAIL reset_values got av=%b bv=%b a=%h b=%h lock=%b sel=%b err=%h rdy=%b want all zero rdy=1",
               A_valid, B_valid, A_out, B_out, Locked, Sel, Err_cnt, Din_ready);
    end
  endtask

  task automatic test_basic_stream();
    do_reset();
    step(4'hA, 1, 1, 1, 1, "stream0");
    checks++;
    if (A_out !== 4'hA || A_valid !== 1 || Locked !== 1) begin
      errors++;
      $display("FAIL stream_first got a=%h v=%b lock=%b want a=A v=1 lock=1", A_out, A_valid, Locked);
    end
    step(4'h5, 1, 0, 1, 1, "stream1");
    checks++;
    if (B_out !== 4'h5 || B_valid !== 1 || Sel !== 1) begin
      errors++;
      $display("FAIL stream_b got b=%h v=%b sel=%b want b=5 v=1 sel=1", B_out, B_valid, Sel);
    end
    step(4'h3, 1, 1, 1, 1, "stream2");
    step(4'hC, 1, 0, 1, 1, "stream3");
    checks++;
    if (B_out !== 4'hC || A_out !== 4'h3 || Err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL stream_end got a=%h b=%h err=%h want a=3 b=C err=00", A_out, B_out, Err_cnt);
    end
  endtask

  task automatic test_hunt_and_errors();
    do_reset();
    step(4'h1, 1, 0, 1, 1, "hunt_drop");
    checks++;
    if (A_valid !== 0 || B_valid !== 0 || Locked !== 0 || Err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL hunt_drop got av=%b bv=%b lock=%b err=%h want 0 0 0 00", A_valid, B_valid, Locked, Err_cnt);
    end
    step(4'h2, 1, 1, 1, 1, "hunt_lock");
    step(4'h7, 1, 1, 1, 1, "resync");
    checks++;
    if (A_out !== 4'h7 || A_valid !== 1 || Err_cnt !== 8'h01 || Locked !== 1) begin
      errors++;
      $display("FAIL resync got a=%h v=%b err=%h lock=%b want a=7 v=1 err=01 lock=1", A_out, A_valid, Err_cnt, Locked);
    end
    step(4'h4, 1, 0, 1, 1, "to_exp_a");
    step(4'h9, 1, 0, 1, 1, "exp_a_drop");
    checks++;
    if (Err_cnt !== 8'h02 || Locked !== 0 || B_valid !== 0 || Sel !== 1) begin
      errors++;
      $display("FAIL exp_a_drop got err=%h lock=%b bv=%b sel=%b want err=02 lock=0 bv=0 sel=1", Err_cnt, Locked, B_valid, Sel);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'hA, 1, 1, 1, 1, "bp_a");
    step(4'h5, 1, 0, 1, 0, "bp_b");
    for (int i = 0; i < 3; i++) begin
      step(4'h3, 1, 1, 1, 0, "bp_stall");
      checks++;
      if (Din_ready !== 0 || B_out !== 4'h5 || B_valid !== 1 || A_valid !== 0) begin
        errors++;
        $display("FAIL bp_stall got rdy=%b b=%h bv=%b av=%b want rdy=0 b=5 bv=1 av=0", Din_ready, B_out, B_valid, A_valid);
      end
    end
    step(4'h3, 1, 1, 0, 1, "bp_release");
    step(4'h8, 1, 1, 1, 1, "bp_reload");
    checks++;
    if (A_valid !== 1 || A_out !== 4'h8 || Err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL bp_reload got av=%b a=%h err=%h want av=1 a=8 err=01", A_valid, A_out, Err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    step(4'h1, 1, 1, 1, 1, "sat_lock");
    for (int i = 0; i < 300; i++) step(4'(i), 1, 1, 1, 1, "sat_err");
    checks++;
    if (Err_cnt !== 8'hFF || Locked !== 1) begin
      errors++;
      $display("FAIL saturation got err=%h lock=%b want err=FF lock=1", Err_cnt, Locked);
    end
  endtask

  task automatic test_random();
    logic fr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      // Mostly follow the expected alternation so the link spends time locked.
      if ($urandom_range(9) < 8) fr = (m_want != 1);
      else fr = 1'($urandom);
      step(4'($urandom), ($urandom_range(3) != 0), fr,
           ($urandom_range(9) < 7), ($urandom_range(9) < 7), "random");
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'hA, 1, 1, 1, 1, "ar_a");
    step(4'h5, 1, 0, 0, 0, "ar_b");
    step(4'h6, 1, 1, 0, 0, "ar_hold");
    Rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (A_valid !== 0 || B_valid !== 0 || Locked !== 0 || Sel !== 0 || B_out !== 4'h0) begin
      errors++;
      $display("FAIL async_reset got av=%b bv=%b lock=%b sel=%b b=%h want all zero", A_valid, B_valid, Locked, Sel, B_out);
    end
    #1;
    Rst_n = 1;
    step(4'h6, 1, 0, 1, 1, "post_rst_drop");
    checks++;
    if (A_valid !== 0 || B_valid !== 0 || Locked !== 0) begin
      errors++;
      $display("FAIL post_rst_drop got av=%b bv=%b lock=%b want 0 0 0", A_valid, B_valid, Locked);
    end
    step(4'h8, 1, 1, 1, 1, "post_rst_frame");
    checks++;
    if (A_out !== 4'h8 || A_valid !== 1 || Locked !== 1) begin
      errors++;
      $display("FAIL post_rst_frame got a=%h av=%b lock=%b want 8 1 1", A_out, A_valid, Locked);
    end
  endtask

  initial begin
    Rst_n = 0; Din = '0; Din_valid = 0; Frame = 0; A_ready = 0; B_ready = 0;
    model_reset();
    test_reset();
    test_basic_stream();
    test_hunt_and_errors();
    test_backpressure();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
